instruction_fetch: RTL and testbench

//  Fetch stage directly downstream of program_counter: reads the current PC, issues one instruction-memory

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/instruction_fetch_if.sv | 49 ++++
 rtl/instruction_fetch.sv | 115 +++++++++++
 tb/tb_instruction_fetch.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module  : fetch_pkg
//  Purpose : Shared types and constants for the instruction fetch stage:
//            fetch FSM state encoding, the reset vector, the per-instruction
//            PC increment, the canonical NOP, and a word-alignment helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package fetch_pkg;

   localparam logic [31:0] RESET_VECTOR = 32'h0100_0000;
   localparam logic [31:0] INST_BYTES   = 32'd4;
   localparam logic [31:0] NOP          = 32'h0000_0013;

   // BOOT : PC is being loaded with the reset vector
   // REQ  : request presented to instruction memory
   // WAIT : request accepted, response pending
   // OUT  : instruction word held for decode
   // DROP : response pending for an address abandoned by a redirect
   typedef enum logic [2:0] {
      BOOT = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      OUT  = 3'd3,
      DROP = 3'd4
   } fetch_state_t;

   // Clears the two byte-offset bits so every fetch address is word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module  : instruction_fetch_if
//  Purpose : Bundles every non-clock signal of the fetch stage: the
//            program_counter load path, the instruction-memory request and
//            response channels, the redirect input and the decode handshake.
//  Ports   : modport master - the fetch stage (drives pc_next/pc_en, memory
//                             request, instruction to decode)
//            modport slave  - the surroundings (program_counter, memory,
//                             branch unit, decode)
//  Rev     : 1.0  initial release
//------------------------------------------------------------------------------
interface instruction_fetch_if;

   // program_counter
   logic [31:0] pc_in;
   logic [31:0] pc_next;
   logic        pc_en;
   // instruction memory
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   // branch / jump redirect
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   // decode
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   modport master (
      input  pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready,
      output pc_next, pc_en, imem_req_valid, imem_req_addr,
             inst_valid, inst_data, inst_pc
   );

   modport slave (
      output pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready,
      input  pc_next, pc_en, imem_req_valid, imem_req_addr,
             inst_valid, inst_data, inst_pc
   );

endinterface : instruction_fetch_if
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module  : instruction_fetch
//  Purpose : Fetch stage behind program_counter. Issues one instruction-memory
//            request at a time for the current PC, hands the returned word to
//            decode over a valid/ready handshake, and loads program_counter
//            with PC+INST_BYTES or a redirect target. A response belonging to
//            an address abandoned by a redirect never reaches decode.
//  Ports   : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - instruction_fetch_if.master (PC load, imem, redirect,
//                     decode handshake)
//  Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR,
   parameter logic [31:0] INST_BYTES   = fetch_pkg::INST_BYTES
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   instruction_fetch_if.master      bus
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;

   logic [31:0] r_req_pc;
   logic [31:0] r_inst_data;
   logic [31:0] r_inst_pc;

   logic [31:0] w_req_pc_inc;
   logic [31:0] w_pc_next;
   logic        w_pc_en;
   logic        w_capture;

   // Wraps naturally at 2^32, so a fetch at 32'hFFFFFFFC continues at 0.
   assign w_req_pc_inc = r_req_pc + INST_BYTES;

   always_comb begin
      w_state_next = r_state;
      w_pc_en      = 1'b0;
      w_pc_next    = w_req_pc_inc;
      w_capture    = 1'b0;

      case (r_state)
         BOOT: begin
            w_pc_en      = 1'b1;
            w_pc_next    = RESET_VECTOR;
            w_state_next = REQ;
         end
         REQ: begin
            if (bus.imem_req_ready) w_state_next = WAIT;
         end
         WAIT: begin
            if (bus.imem_rsp_valid) begin
               w_pc_en      = 1'b1;
               w_capture    = 1'b1;
               w_state_next = OUT;
            end
         end
         OUT: begin
            if (bus.inst_ready) w_state_next = REQ;
         end
         DROP: begin
            if (bus.imem_rsp_valid) w_state_next = REQ;
         end
         default: w_state_next = BOOT;
      endcase

      // A redirect wins over everything except the boot load. Any request the
      // memory still owes us becomes an orphan that DROP has to absorb; a
      // response arriving in the redirect cycle itself is simply discarded.
      if (bus.redirect_valid && (r_state != BOOT)) begin
         w_pc_en   = 1'b1;
         w_pc_next = word_align(bus.redirect_pc);
         w_capture = 1'b0;
         case (r_state)
            REQ:     w_state_next = bus.imem_req_ready ? DROP : REQ;
            WAIT:    w_state_next = bus.imem_rsp_valid ? REQ  : DROP;
            OUT:     w_state_next = REQ;
            // An orphan answered in the redirect cycle leaves nothing owed.
            DROP:    w_state_next = bus.imem_rsp_valid ? REQ  : DROP;
            default: w_state_next = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= BOOT;
         r_req_pc    <= 32'd0;
         r_inst_data <= 32'd0;
         r_inst_pc   <= 32'd0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == REQ) && bus.imem_req_ready) r_req_pc <= bus.pc_in;
         if (w_capture) begin
            r_inst_data <= bus.imem_rsp_data;
            r_inst_pc   <= r_req_pc;
         end
      end
   end

   assign bus.pc_en          = w_pc_en;
   assign bus.pc_next        = w_pc_next;
   assign bus.imem_req_valid = (r_state == REQ);
   assign bus.imem_req_addr  = bus.pc_in;
   assign bus.inst_valid     = (r_state == OUT);
   assign bus.inst_data      = r_inst_data;
   assign bus.inst_pc        = r_inst_pc;

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
//  Module  : tb_instruction_fetch
//  Purpose : Self-checking bench for instruction_fetch. Models program_counter
//            and a variable-latency instruction memory, and keeps a
//            program-order model (next PC owed to decode, whether a word is
//            held, which outstanding request is still wanted).
//  Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam logic [31:0] RV = 32'h0100_0000;

   typedef struct {
      logic [31:0] addr;
      int          cnt;
      bit          live;
   } ment_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instruction_fetch_if bus();

   instruction_fetch #(
      .RESET_VECTOR (RV),
      .INST_BYTES   (32'd4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // program_counter model
   logic [31:0] pc_reg;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          pc_reg <= RV;
      else if (bus.pc_en)  pc_reg <= bus.pc_next;
   end
   assign bus.pc_in = pc_reg;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int idx   = -1;
   int stall = 0;

   // memory model
   ment_t q[$];
   ment_t rsp_ent;
   bit    rsp_now;

   // behavioural model
   logic [31:0] exp_pc = RV;
   bit          exp_have = 0;
   bit          prev_pend = 0;
   logic [31:0] prev_addr = 0;

   // knobs
   int rdy_pct = 100, ird_pct = 100, lat_min = 0, lat_max = 0, redir_permil = 0;
   int rdy_hold = 0, ird_hold = 0, rst_cnt = 0;
   bit redir_wait = 0, redir_rsp = 0, redir_once = 0, rst_in_wait = 0, rst_hit = 0;
   logic [31:0] tgt_wait, tgt_rsp, tgt_once;
   bit rec_req = 0, rec_out = 0;

   // logs
   logic [31:0] after_rst_acc[$], after_rst_deliv[$], after_redir[$];
   int          after_rst_cyc[$];
   logic [31:0] held_req[$], held_pc[$], held_data[$];
   logic [31:0] last_redir_pcn = 0, wrap_pcn = 32'hDEAD_BEEF;
   bit          wrap_seen = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   function automatic logic [31:0] rand_target();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(3) == 0) r = 32'hFFFF_FFF0 | {28'd0, r[3:0]};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic drive();
      rsp_now = 0;
      if (rst_cnt > 0) begin rst_cnt--; rst_n = 1'b0; end
      else rst_n = 1'b1;
      if (rst_in_wait && q.size() > 0 && q[0].live && q[0].cnt > 0) begin
         rst_n = 1'b0; rst_in_wait = 0; rst_cnt = 2; rst_hit = 1;
      end
      bus.imem_rsp_data  = $urandom;
      bus.redirect_pc    = $urandom;
      bus.redirect_valid = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      if (!rst_n) begin
         q.delete();
         bus.imem_req_ready = 1'b0;
         bus.inst_ready     = 1'b0;
         idx = -1; exp_pc = RV; exp_have = 0; prev_pend = 0;
         return;
      end
      idx++;
      if (rdy_hold > 0 && bus.imem_req_valid) begin
         bus.imem_req_ready = 1'b0; rdy_hold--;
      end else bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
      if (ird_hold > 0 && bus.inst_valid) begin
         bus.inst_ready = 1'b0; ird_hold--;
      end else bus.inst_ready = ($urandom_range(99) < ird_pct);
      if (q.size() > 0) begin
         if (q[0].cnt == 0) begin
            rsp_ent = q.pop_front();
            rsp_now = 1;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(rsp_ent.addr);
         end else q[0].cnt = q[0].cnt - 1;
      end
      if (idx >= 1) begin
         if (redir_wait && q.size() > 0 && q[0].live && !rsp_now) begin
            bus.redirect_valid = 1'b1; bus.redirect_pc = tgt_wait; redir_wait = 0;
         end else if (redir_rsp && rsp_now && rsp_ent.live) begin
            bus.redirect_valid = 1'b1; bus.redirect_pc = tgt_rsp; redir_rsp = 0;
         end else if (redir_once) begin
            bus.redirect_valid = 1'b1; bus.redirect_pc = tgt_once; redir_once = 0;
         end else if ($urandom_range(999) < redir_permil) begin
            bus.redirect_valid = 1'b1; bus.redirect_pc = rand_target();
         end
      end
   endtask

   task automatic eval();
      bit          redir;
      logic [31:0] tgt_al;
      ment_t       e;
      cyc++;
      redir  = bus.redirect_valid;
      tgt_al = bus.redirect_pc & 32'hFFFF_FFFC;
      if (!rst_n) begin
         chk("rst_inst_valid", 32'(bus.inst_valid), 0);
         chk("rst_req_valid",  32'(bus.imem_req_valid), 0);
         chk("rst_inst_data",  bus.inst_data, 0);
         chk("rst_inst_pc",    bus.inst_pc, 0);
         chk("rst_pc_en",      32'(bus.pc_en), 1);
         chk("rst_pc_next",    bus.pc_next, RV);
         after_rst_acc.delete(); after_rst_deliv.delete(); after_rst_cyc.delete();
         stall = 0; prev_pend = 0;
         return;
      end
      chk("inst_valid", 32'(bus.inst_valid), 32'(exp_have));
      if (bus.inst_valid) begin
         chk("inst_pc",   bus.inst_pc, exp_pc);
         chk("inst_data", bus.inst_data, mem_word(exp_pc));
         chk("no_req_in_out", 32'(bus.imem_req_valid), 0);
      end
      if (prev_pend) begin
         chk("req_held_valid", 32'(bus.imem_req_valid), 1);
         chk("req_held_addr",  bus.imem_req_addr, prev_addr);
      end
      if (idx == 0) begin
         chk("boot_pc_en",     32'(bus.pc_en), 1);
         chk("boot_pc_next",   bus.pc_next, RV);
         chk("boot_req_valid", 32'(bus.imem_req_valid), 0);
      end else if (redir) begin
         chk("redir_pc_en",   32'(bus.pc_en), 1);
         chk("redir_pc_next", bus.pc_next, tgt_al);
         last_redir_pcn = bus.pc_next;
      end else if (rsp_now && rsp_ent.live) begin
         chk("rsp_pc_en",   32'(bus.pc_en), 1);
         chk("rsp_pc_next", bus.pc_next, rsp_ent.addr + 32'd4);
         if (rsp_ent.addr == 32'hFFFF_FFFC) begin wrap_seen = 1; wrap_pcn = bus.pc_next; end
      end else begin
         chk("idle_pc_en", 32'(bus.pc_en), 0);
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         chk("one_outstanding", 32'(q.size()) + 32'(rsp_now), 0);
         if (!redir) chk("req_addr", bus.imem_req_addr, exp_pc);
         e.addr = bus.imem_req_addr;
         e.cnt  = lat_min + int'($urandom_range(lat_max - lat_min));
         e.live = !redir;
         q.push_back(e);
         after_rst_acc.push_back(bus.imem_req_addr);
      end
      if (rec_req && bus.imem_req_valid && !bus.imem_req_ready) held_req.push_back(bus.imem_req_addr);
      if (rec_out && bus.inst_valid && !bus.inst_ready) begin
         held_pc.push_back(bus.inst_pc);
         held_data.push_back(bus.inst_data);
      end
      prev_pend = bus.imem_req_valid && !bus.imem_req_ready && !redir;
      prev_addr = bus.imem_req_addr;

      stall++;
      if (bus.inst_valid && bus.inst_ready && !redir) begin
         after_rst_deliv.push_back(bus.inst_pc);
         after_rst_cyc.push_back(cyc);
         after_redir.push_back(bus.inst_pc);
         exp_pc   = exp_pc + 32'd4;
         exp_have = 0;
         stall    = 0;
      end
      if (rsp_now && rsp_ent.live && !redir) exp_have = 1;
      if (redir) begin
         exp_have = 0;
         exp_pc   = tgt_al;
         foreach (q[i]) q[i].live = 1'b0;
         after_redir.delete();
         stall = 0;
      end
      if (stall > 200) begin
         chk("progress_stall", 32'(stall), 0);
         stall = 0;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         drive();
         #1;
         eval();
      end
   endtask

   function automatic logic [31:0] qget(input logic [31:0] qq[$], input int n);
      return (qq.size() > n) ? qq[n] : 32'hDEAD_BEEF;
   endfunction

   initial begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      bus.inst_ready     = 1'b0;

      // Reset release with a zero-wait memory and an always-ready decode.
      rst_cnt = 3;
      run(14);
      chk("first_req_addr",   qget(after_rst_acc, 0), 32'h0100_0000);
      chk("first_inst_pc",    qget(after_rst_deliv, 0), 32'h0100_0000);
      chk("second_inst_pc",   qget(after_rst_deliv, 1), 32'h0100_0004);
      chk("throughput_3cyc",
          32'((after_rst_cyc.size() > 1) ? after_rst_cyc[1] - after_rst_cyc[0] : -1), 3);

      // Memory withholds ready for 5 request cycles.
      held_req.delete(); rec_req = 1; rdy_hold = 5;
      run(15);
      rec_req = 0;
      chk("req_stall_cycles", 32'(held_req.size()), 5);
      foreach (held_req[i]) chk("req_stall_addr_const", held_req[i], held_req[0]);

      // Decode withholds ready for 4 cycles.
      held_pc.delete(); held_data.delete(); rec_out = 1; ird_hold = 4;
      run(15);
      rec_out = 0;
      chk("out_stall_cycles", 32'(held_pc.size()), 4);
      foreach (held_pc[i]) begin
         chk("out_stall_pc_const",   held_pc[i], held_pc[0]);
         chk("out_stall_data_const", held_data[i], held_data[0]);
      end

      // Redirect while a slow response is pending.
      lat_min = 3; lat_max = 3; redir_wait = 1; tgt_wait = 32'h0100_0103;
      run(25);
      chk("redir_wait_fired",   32'(redir_wait), 0);
      chk("redir_wait_pc_next", last_redir_pcn, 32'h0100_0100);
      chk("redir_wait_next_pc", qget(after_redir, 0), 32'h0100_0100);

      // Redirect in the same cycle as the response.
      lat_min = 0; lat_max = 2; redir_rsp = 1; tgt_rsp = 32'h0200_0000;
      run(20);
      chk("redir_rsp_fired",   32'(redir_rsp), 0);
      chk("redir_rsp_pc_next", last_redir_pcn, 32'h0200_0000);
      chk("redir_rsp_next_pc", qget(after_redir, 0), 32'h0200_0000);

      // Fetch at the top of the address space wraps to zero.
      lat_min = 0; lat_max = 0; redir_once = 1; tgt_once = 32'hFFFF_FFFC;
      run(15);
      chk("wrap_first_pc",  qget(after_redir, 0), 32'hFFFF_FFFC);
      chk("wrap_second_pc", qget(after_redir, 1), 32'h0000_0000);
      chk("wrap_seen",      32'(wrap_seen), 1);
      chk("wrap_pc_next",   wrap_pcn, 32'h0000_0000);

      // Reset while a response is outstanding.
      lat_min = 3; lat_max = 3; rst_in_wait = 1;
      run(30);
      chk("rst_wait_hit",    32'(rst_hit), 1);
      chk("rst_wait_req",    qget(after_rst_acc, 0), 32'h0100_0000);
      chk("rst_wait_inst0",  qget(after_rst_deliv, 0), 32'h0100_0000);
      chk("rst_wait_inst1",  qget(after_rst_deliv, 1), 32'h0100_0004);

      // Randomised traffic.
      for (int chunk = 0; chunk < 25; chunk++) begin
         rdy_pct      = 30 + int'($urandom_range(70));
         ird_pct      = 30 + int'($urandom_range(70));
         lat_min      = 0;
         lat_max      = int'($urandom_range(4));
         redir_permil = int'($urandom_range(40));
         if (chunk % 8 == 7) rst_cnt = 2;
         run(100);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_instruction_fetch
`default_nettype wire
